nv_nvdla_glb_csb_master: RTL and testbench
==========================================

NV_NVDLA_GLB_CSB_MASTER -- requirements
Module: nv_nvdla_glb_csb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning response-wait limit in cycles (1..65535).
REQ-002 SHALL have port nvdla_core_clk  in  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port nvdla_core_rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports host_req_valid in 1, host_req_ready out 1, host_req_addr in 22, host_req_wdat in 32, host_req_write in 1, host_req_nposted in 1: the host register-access request.
REQ-005 SHALL have ports host_rsp_valid out 1, host_rsp_write out 1, host_rsp_error out 1, host_rsp_rdat out 32: the single-cycle completion to the host.
REQ-006 SHALL have ports csb2glb_req_pvld out 1, csb2glb_req_prdy in 1, csb2glb_req_pd out 63: the request to the GLB register block.
REQ-007 SHALL have ports glb2csb_resp_valid in 1, glb2csb_resp_pd in 34: the response from the GLB register block.

Function
REQ-008 SHALL pack csb2glb_req_pd as [62:61]=2'b00 level, [60:57]=4'hF wrbe, [56]=0 srcpriv, [55]=nposted, [54]=write, [53:22]=wdat, [21:0]=addr.
REQ-009 SHALL decode glb2csb_resp_pd as [33]=type (0 read, 1 write), [32]=error, [31:0]=rdat.
REQ-010 SHALL implement states IDLE, REQ, WAIT, RSP; exactly one request outstanding.
REQ-011 IDLE: host_req_ready=1; on host_req_valid latch addr/wdat/write/nposted, go REQ; ready=0 in all other states.
REQ-012 REQ: csb2glb_req_pvld=1 with pd held stable until csb2glb_req_prdy=1; then posted write (write=1, nposted=0) goes RSP, otherwise goes WAIT with timeout counter cleared.
REQ-013 WAIT: counter increments each cycle; on glb2csb_resp_valid capture type/error/rdat, go RSP.
REQ-014 RSP: host_rsp_valid=1 for exactly one cycle, then IDLE; posted write reports write=1, error=0, rdat=0.
REQ-015 SHALL set host_rsp_error=1 if captured response type differs from the latched write flag, or captured error=1.
REQ-016 Latency with prdy=1: host accept cycle N -> pvld N+1; posted write host_rsp_valid N+2; read/non-posted write with GLB response at N+3 -> host_rsp_valid N+4.
REQ-017 glb2csb_resp_valid outside WAIT SHALL be ignored and not corrupt later transactions.
REQ-018 All outputs except host_req_ready SHALL be driven from registers.

Reset
REQ-019 On nvdla_core_rst=1 at a clock edge: state IDLE, counter 0, csb2glb_req_pvld=0, host_rsp_valid=0, host_rsp_write=0, host_rsp_error=0, host_rsp_rdat=0, csb2glb_req_pd=0.
REQ-020 Reset mid-transaction SHALL abort it silently: no host_rsp_valid emitted; a later stale GLB response is ignored per REQ-017.

Configuration
REQ-021 With macro NVDLA_GLB_CSB_TIMEOUT_EN defined: in WAIT, when counter reaches TIMEOUT_CYCLES without response, go RSP with error=1, rdat=0, write=latched write.
REQ-022 If response and timeout coincide in the same cycle, the response SHALL win (error per REQ-015 only).
REQ-023 Without NVDLA_GLB_CSB_TIMEOUT_EN: no counter logic; WAIT exits only on glb2csb_resp_valid.

Verification
REQ-024 Read addr 0x000004, GLB resp_pd={0,0,0x0000_00A5} at N+3 -> host_rsp_valid at N+4, rdat=0xA5, write=0, error=0; pd[54]=0, pd[21:0]=0x4.
REQ-025 Posted write addr 0x10 wdat 0xDEADBEEF, prdy=1 -> pvld at N+1 with pd[53:22]=0xDEADBEEF, pd[55]=0; host_rsp_valid N+2, write=1, error=0.
REQ-026 Non-posted write, prdy held 0 for 3 cycles -> pd stable while stalled, host_req_ready=0; resp type=1 -> rsp error=0; resp type=0 -> rsp error=1.
REQ-027 TIMEOUT_EN, TIMEOUT_CYCLES=4, read with no response -> host_rsp_valid error=1 rdat=0; late response then ignored, next read completes correctly.
REQ-028 Assert reset in WAIT, then release and deliver stale response -> no host_rsp_valid; all outputs at reset values.

Source files
------------

// File: rtl/nv_nvdla_glb_csb_master.sv
// nv_nvdla_glb_csb_master: one-outstanding CSB master bridging host register accesses to the GLB block; define NVDLA_GLB_CSB_TIMEOUT_EN for a response timeout
module nv_nvdla_glb_csb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic [21:0] host_req_addr,
  input  logic [31:0] host_req_wdat,
  input  logic        host_req_write,
  input  logic        host_req_nposted,
  output logic        host_rsp_valid,
  output logic        host_rsp_write,
  output logic        host_rsp_error,
  output logic [31:0] host_rsp_rdat,
  output logic        csb2glb_req_pvld,
  input  logic        csb2glb_req_prdy,
  output logic [62:0] csb2glb_req_pd,
  input  logic        glb2csb_resp_valid,
  input  logic [33:0] glb2csb_resp_pd
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end
  state_t      state_q, state_d;
  logic        pvld_q, pvld_d;
  logic [62:0] pd_q, pd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdat_q, rsp_rdat_d;
  logic        lat_write, lat_posted;
  // The held request payload doubles as the latched write/nposted flags
  assign lat_write  = pd_q[54];
  assign lat_posted = pd_q[54] & ~pd_q[55];
  assign host_req_ready   = state_q == S_IDLE;
  assign csb2glb_req_pvld = pvld_q;
  assign csb2glb_req_pd   = pd_q;
  assign host_rsp_valid   = rsp_valid_q;
  assign host_rsp_write   = rsp_write_q;
  assign host_rsp_error   = rsp_error_q;
  assign host_rsp_rdat    = rsp_rdat_q;
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout;
  assign timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);
`endif
  // Next-state and next-output computation; a GLB response only counts in WAIT
  always_comb begin
    state_d     = state_q;
    pvld_d      = pvld_q;
    pd_d        = pd_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_error_d = rsp_error_q;
    rsp_rdat_d  = rsp_rdat_q;
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (host_req_valid) begin
        state_d = S_REQ;
        pvld_d  = 1'b1;
        pd_d    = {2'b00, 4'hF, 1'b0, host_req_nposted, host_req_write, host_req_wdat, host_req_addr};
      end
      S_REQ: if (csb2glb_req_prdy) begin
        pvld_d = 1'b0;
        if (lat_posted) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdat_d  = 32'h0;
        end else begin
          state_d = S_WAIT;
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
          cnt_d   = 16'h0;
`endif
        end
      end
      S_WAIT: begin
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        if (glb2csb_resp_valid) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_write_d = lat_write;
          rsp_error_d = (glb2csb_resp_pd[33] != lat_write) | glb2csb_resp_pd[32];
          rsp_rdat_d  = glb2csb_resp_pd[31:0];
        end
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
        else if (timeout) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_write_d = lat_write;
          rsp_error_d = 1'b1;
          rsp_rdat_d  = 32'h0;
        end
`endif
      end
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // State and registered outputs; reset aborts any transaction silently
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q     <= S_IDLE;
      pvld_q      <= 1'b0;
      pd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdat_q  <= '0;
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pvld_q      <= pvld_d;
      pd_q        <= pd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdat_q  <= rsp_rdat_d;
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_nv_nvdla_glb_csb_master.sv
// tb_nv_nvdla_glb_csb_master: directed plus randomized transactions checked against a transaction-level model
module tb_nv_nvdla_glb_csb_master;
  localparam int TO = 4;
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
  localparam int MAXD = TO - 1;
`else
  localparam int MAXD = 8;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req_valid = 1'b0;
  logic        host_req_ready;
  logic [21:0] host_req_addr = '0;
  logic [31:0] host_req_wdat = '0;
  logic        host_req_write = 1'b0;
  logic        host_req_nposted = 1'b0;
  logic        host_rsp_valid;
  logic        host_rsp_write;
  logic        host_rsp_error;
  logic [31:0] host_rsp_rdat;
  logic        pvld;
  logic        prdy = 1'b0;
  logic [62:0] pd;
  logic        resp_valid = 1'b0;
  logic [33:0] resp_pd = '0;
  int n_cmp = 0;
  int n_err = 0;

  nv_nvdla_glb_csb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_addr(host_req_addr), .host_req_wdat(host_req_wdat),
    .host_req_write(host_req_write), .host_req_nposted(host_req_nposted),
    .host_rsp_valid(host_rsp_valid), .host_rsp_write(host_rsp_write),
    .host_rsp_error(host_rsp_error), .host_rsp_rdat(host_rsp_rdat),
    .csb2glb_req_pvld(pvld), .csb2glb_req_prdy(prdy), .csb2glb_req_pd(pd),
    .glb2csb_resp_valid(resp_valid), .glb2csb_resp_pd(resp_pd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [62:0] obs, input logic [62:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [62:0] exp_pd(logic [21:0] a, logic [31:0] w, logic wr, logic np);
    return {2'b00, 4'hF, 1'b0, np, wr, w, a};
  endfunction

  task automatic idle_rsp_chk(input string tag);
    chk({tag, ":rsp_valid"}, 63'(host_rsp_valid), 63'd0);
    chk({tag, ":pvld"}, 63'(pvld), 63'd0);
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, ":rsp_valid"}, 63'(host_rsp_valid), 63'd0);
    chk({tag, ":rsp_write"}, 63'(host_rsp_write), 63'd0);
    chk({tag, ":rsp_error"}, 63'(host_rsp_error), 63'd0);
    chk({tag, ":rsp_rdat"}, 63'(host_rsp_rdat), 63'd0);
    chk({tag, ":pvld"}, 63'(pvld), 63'd0);
    chk({tag, ":pd"}, pd, 63'd0);
    chk({tag, ":ready"}, 63'(host_req_ready), 63'd1);
  endtask

  // Issue one request at the current negedge and walk it to completion.
  // stall: cycles prdy stays low; rdly: WAIT cycles before the GLB response; no_resp: let it time out
  task automatic txn(input string tag, input logic [21:0] a, input logic [31:0] w, input logic wr,
                     input logic np, input int stall, input int rdly, input logic rtype,
                     input logic rerr, input logic [31:0] rdat, input bit no_resp);
    logic [62:0] epd;
    bit posted;
    epd = exp_pd(a, w, wr, np);
    posted = wr && !np;
    chk({tag, ":ready_idle"}, 63'(host_req_ready), 63'd1);
    host_req_valid = 1'b1; host_req_addr = a; host_req_wdat = w;
    host_req_write = wr; host_req_nposted = np;
    @(negedge clk);
    host_req_valid = 1'b0; host_req_addr = $urandom; host_req_wdat = $urandom;
    host_req_write = $urandom; host_req_nposted = $urandom;
    chk({tag, ":pvld"}, 63'(pvld), 63'd1);
    chk({tag, ":pd"}, pd, epd);
    chk({tag, ":ready_busy"}, 63'(host_req_ready), 63'd0);
    for (int i = 0; i < stall; i++) begin
      prdy = 1'b0;
      @(negedge clk);
      chk({tag, ":pvld_stall"}, 63'(pvld), 63'd1);
      chk({tag, ":pd_stall"}, pd, epd);
      chk({tag, ":ready_stall"}, 63'(host_req_ready), 63'd0);
    end
    prdy = 1'b1;
    @(negedge clk);
    prdy = 1'b0;
    chk({tag, ":pvld_drop"}, 63'(pvld), 63'd0);
    if (!posted) begin
      for (int i = 0; i < (no_resp ? TO : rdly); i++) begin
        chk({tag, ":no_rsp_wait"}, 63'(host_rsp_valid), 63'd0);
        chk({tag, ":ready_wait"}, 63'(host_req_ready), 63'd0);
        @(negedge clk);
      end
      if (!no_resp) begin
        resp_valid = 1'b1;
        resp_pd = {rtype, rerr, rdat};
        @(negedge clk);
        resp_valid = 1'b0;
        resp_pd = $urandom;
      end
    end
    chk({tag, ":rsp_valid"}, 63'(host_rsp_valid), 63'd1);
    chk({tag, ":rsp_write"}, 63'(host_rsp_write), 63'(posted ? 1'b1 : wr));
    chk({tag, ":rsp_error"}, 63'(host_rsp_error),
        63'(posted ? 1'b0 : (no_resp ? 1'b1 : ((rtype != wr) | rerr))));
    chk({tag, ":rsp_rdat"}, 63'(host_rsp_rdat), 63'((posted || no_resp) ? 32'h0 : rdat));
    @(negedge clk);
    chk({tag, ":rsp_one_cycle"}, 63'(host_rsp_valid), 63'd0);
    chk({tag, ":ready_back"}, 63'(host_req_ready), 63'd1);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    reset_outputs_chk("reset");
    rst = 1'b0;
    @(negedge clk);
    reset_outputs_chk("post_reset");
    // Read with GLB response at N+3
    txn("read_a5", 22'h000004, 32'h0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 32'h0000_00A5, 1'b0);
    // Posted write
    txn("posted_wr", 22'h000010, 32'hDEADBEEF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Non-posted write stalled three cycles, matching and mismatching response type
    txn("np_wr_ok", 22'h000020, 32'h1234_5678, 1'b1, 1'b1, 3, 1, 1'b1, 1'b0, 32'h0, 1'b0);
    txn("np_wr_badtype", 22'h000024, 32'h8765_4321, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Read carrying GLB error flag
    txn("read_err", 22'h3FFFFF, 32'h0, 1'b0, 1'b1, 1, 2, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    // Stale response while idle is ignored
    resp_valid = 1'b1; resp_pd = {1'b1, 1'b1, 32'hBAD0_BAD0};
    @(negedge clk);
    resp_valid = 1'b0;
    idle_rsp_chk("stale_idle");
    @(negedge clk);
    idle_rsp_chk("stale_idle2");
    txn("after_stale", 22'h000008, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
    // Reset while waiting for a response, then a stale response
    host_req_valid = 1'b1; host_req_addr = 22'h44; host_req_write = 1'b0; host_req_nposted = 1'b0;
    @(negedge clk);
    host_req_valid = 1'b0; prdy = 1'b1;
    @(negedge clk);
    prdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_outputs_chk("rst_in_wait");
    resp_valid = 1'b1; resp_pd = {1'b0, 1'b0, 32'h5555_AAAA};
    @(negedge clk);
    resp_valid = 1'b0;
    reset_outputs_chk("rst_stale1");
    @(negedge clk);
    reset_outputs_chk("rst_stale2");
    txn("after_rst", 22'h000048, 32'h0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 32'hC0FF_EE00, 1'b0);
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
    // Timeout, late response ignored, then a clean read
    txn("timeout", 22'h000050, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    resp_valid = 1'b1; resp_pd = {1'b0, 1'b0, 32'h7777_7777};
    @(negedge clk);
    resp_valid = 1'b0;
    idle_rsp_chk("late_resp");
    txn("after_timeout", 22'h000054, 32'h0, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0, 32'h0000_1111, 1'b0);
    // Response on the final WAIT cycle beats the timeout
    txn("resp_wins", 22'h000058, 32'h0, 1'b0, 1'b0, 0, TO - 1, 1'b0, 1'b0, 32'h0000_2222, 1'b0);
`endif
    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      logic wr, np, rt, re;
      wr = 1'($urandom); np = 1'($urandom);
      rt = ($urandom_range(0, 3) == 0) ? ~wr : wr;
      re = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        resp_valid = 1'b1; resp_pd = {$urandom, 2'($urandom)};
        @(negedge clk);
        resp_valid = 1'b0;
        idle_rsp_chk("rand_stale");
      end
      txn($sformatf("rand%0d", k), 22'($urandom), $urandom, wr, np,
          $urandom_range(0, 3), $urandom_range(0, MAXD), rt, re, $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
